reg_read_arbiter: RTL and testbench



---
 rtl/reg_read_arbiter_pkg.sv | 21 ++
 rtl/reg_read_arbiter_rr.sv | 33 +++
 rtl/reg_read_arbiter.sv | 98 +++++++++
 tb/tb_reg_read_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_read_arbiter_pkg.sv
// Shared constants and operand type for the register-file read-port arbiter.
// Also holds the x0 sanitisation helper used before the response register.
package reg_read_arbiter_pkg;

    localparam int ROB_WIDTH_BIT = 4;
    localparam int REG_ID_BIT    = 5;
    localparam logic [REG_ID_BIT-1:0] ZERO_REG_ID = '0;

    typedef struct packed {
        logic [31:0]              val;
        logic                     has_dep;
        logic [ROB_WIDTH_BIT-1:0] dep;
    } operand_t;

    // x0 always reads as a ready zero, whatever the regfile bypass reports.
    function automatic operand_t sanitise(input logic [REG_ID_BIT-1:0] id,
                                          input operand_t op);
        return (id == ZERO_REG_ID) ? operand_t'('0) : op;
    endfunction

endpackage

// File: rtl/reg_read_arbiter_rr.sv
// Round-robin arbiter: scans req starting at ptr, wrapping, first set bit wins.
// Produces a one-hot grant and the winner index; all zero when disabled.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int REQ_BIT = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic [REQ_BIT-1:0] ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [REQ_BIT-1:0] winner
);

    logic [REQ_BIT-1:0] idx;

    // Walk from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        grant  = '0;
        winner = '0;
        idx    = '0;
        if (enable) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = REQ_BIT'((int'(ptr) + k) % NUM_REQ);
                if (req[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    winner     = idx;
                end
            end
        end
    end

endmodule

// File: rtl/reg_read_arbiter.sv
// Shares the two regfile read ports among NUM_REQ requesters, one grant per cycle,
// and returns the captured operands to the granted requester one cycle later.
module reg_read_arbiter
    import reg_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int REQ_BIT = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          rob_clear,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [REG_ID_BIT*NUM_REQ-1:0] req_rs1,
    input  logic [REG_ID_BIT*NUM_REQ-1:0] req_rs2,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [REG_ID_BIT-1:0]         get_id1,
    output logic [REG_ID_BIT-1:0]         get_id2,
    input  logic [31:0]                   get_val1,
    input  logic [31:0]                   get_val2,
    input  logic                          get_has_dep1,
    input  logic                          get_has_dep2,
    input  logic [ROB_WIDTH_BIT-1:0]      get_dep1,
    input  logic [ROB_WIDTH_BIT-1:0]      get_dep2,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [31:0]                   resp_val1,
    output logic [31:0]                   resp_val2,
    output logic                          resp_has_dep1,
    output logic                          resp_has_dep2,
    output logic [ROB_WIDTH_BIT-1:0]      resp_dep1,
    output logic [ROB_WIDTH_BIT-1:0]      resp_dep2
);

    logic [REQ_BIT-1:0] rr_ptr;
    logic [REQ_BIT-1:0] winner;
    logic [REQ_BIT-1:0] next_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] resp_owner_q;
    operand_t           op1_d, op2_d;
    operand_t           resp1_q, resp2_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .REQ_BIT (REQ_BIT)
    ) u_rr_arbiter (
        .req    (req_valid),
        .enable (rdy_in & ~rob_clear),
        .ptr    (rr_ptr),
        .grant  (grant),
        .winner (winner)
    );

    assign req_ready = grant;

    // AND-OR mux on the one-hot grant; no winner leaves the ids at x0.
    always_comb begin
        get_id1 = '0;
        get_id2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                get_id1 = get_id1 | req_rs1[i*REG_ID_BIT +: REG_ID_BIT];
                get_id2 = get_id2 | req_rs2[i*REG_ID_BIT +: REG_ID_BIT];
            end
        end
    end

    assign op1_d    = sanitise(get_id1, '{val: get_val1, has_dep: get_has_dep1, dep: get_dep1});
    assign op2_d    = sanitise(get_id2, '{val: get_val2, has_dep: get_has_dep2, dep: get_dep2});
    assign next_ptr = (winner == REQ_BIT'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_ptr       <= '0;
            resp_owner_q <= '0;
            resp1_q      <= '0;
            resp2_q      <= '0;
        end else if (rdy_in) begin
            if (|grant) begin
                resp_owner_q <= grant;
                resp1_q      <= op1_d;
                resp2_q      <= op2_d;
                rr_ptr       <= next_ptr;
            end else begin
                resp_owner_q <= '0;
            end
        end
    end

    // A flush in the response cycle kills the strobe but not the held data.
    assign resp_valid    = resp_owner_q & {NUM_REQ{~rob_clear}};
    assign resp_val1     = resp1_q.val;
    assign resp_val2     = resp2_q.val;
    assign resp_has_dep1 = resp1_q.has_dep;
    assign resp_has_dep2 = resp2_q.has_dep;
    assign resp_dep1     = resp1_q.dep;
    assign resp_dep2     = resp2_q.dep;

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Self-checking bench for reg_read_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_reg_read_arbiter;
    import reg_read_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int RB = 2;

    logic clk_in = 1'b0;
    logic rst_in, rdy_in, rob_clear;
    logic [N-1:0]   req_valid;
    logic [5*N-1:0] req_rs1, req_rs2;
    logic [N-1:0]   req_ready;
    logic [4:0]     get_id1, get_id2;
    logic [31:0]    get_val1, get_val2;
    logic           get_has_dep1, get_has_dep2;
    logic [ROB_WIDTH_BIT-1:0] get_dep1, get_dep2;
    logic [N-1:0]   resp_valid;
    logic [31:0]    resp_val1, resp_val2;
    logic           resp_has_dep1, resp_has_dep2;
    logic [ROB_WIDTH_BIT-1:0] resp_dep1, resp_dep2;

    reg_read_arbiter #(.NUM_REQ(N), .REQ_BIT(RB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .req_valid(req_valid), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_ready(req_ready),
        .get_id1(get_id1), .get_id2(get_id2), .get_val1(get_val1), .get_val2(get_val2),
        .get_has_dep1(get_has_dep1), .get_has_dep2(get_has_dep2),
        .get_dep1(get_dep1), .get_dep2(get_dep2),
        .resp_valid(resp_valid), .resp_val1(resp_val1), .resp_val2(resp_val2),
        .resp_has_dep1(resp_has_dep1), .resp_has_dep2(resp_has_dep2),
        .resp_dep1(resp_dep1), .resp_dep2(resp_dep2)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Reference model: pointer, response owner (-1 = none) and held operands.
    int m_ptr, m_owner, last_win;
    logic [31:0] m_val1, m_val2;
    logic m_hd1, m_hd2;
    logic [ROB_WIDTH_BIT-1:0] m_dep1, m_dep2;
    logic [31:0] sv1, sv2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [4:0] rs1_of(input int i);
        return req_rs1[i*5 +: 5];
    endfunction

    function automatic logic [4:0] rs2_of(input int i);
        return req_rs2[i*5 +: 5];
    endfunction

    function automatic int model_winner();
        if (!rdy_in || rob_clear) return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; last_win = -1;
        m_val1 = '0; m_val2 = '0; m_hd1 = 1'b0; m_hd2 = 1'b0; m_dep1 = '0; m_dep2 = '0;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [4:0] b);
        req_rs1[i*5 +: 5] = a;
        req_rs2[i*5 +: 5] = b;
    endtask

    task automatic rand_regfile();
        get_val1     = $urandom;
        get_val2     = $urandom;
        get_has_dep1 = 1'($urandom_range(0, 1));
        get_has_dep2 = 1'($urandom_range(0, 1));
        get_dep1     = ROB_WIDTH_BIT'($urandom);
        get_dep2     = ROB_WIDTH_BIT'($urandom);
    endtask

    function automatic logic [4:0] rid();
        if ($urandom_range(0, 3) == 0) return 5'd0;
        return 5'($urandom_range(1, 31));
    endfunction

    // Called at posedge+1; samples at the following negedge.
    task automatic check_now();
        int w;
        #4;
        w = model_winner();
        chk("req_ready", 32'(req_ready), 32'(onehot(w)));
        chk("get_id1", 32'(get_id1), (w >= 0) ? 32'(rs1_of(w)) : 32'd0);
        chk("get_id2", 32'(get_id2), (w >= 0) ? 32'(rs2_of(w)) : 32'd0);
        chk("resp_valid", 32'(resp_valid), rob_clear ? 32'd0 : 32'(onehot(m_owner)));
        chk("resp_val1", resp_val1, m_val1);
        chk("resp_val2", resp_val2, m_val2);
        chk("resp_has_dep1", 32'(resp_has_dep1), 32'(m_hd1));
        chk("resp_has_dep2", 32'(resp_has_dep2), 32'(m_hd2));
        chk("resp_dep1", 32'(resp_dep1), 32'(m_dep1));
        chk("resp_dep2", 32'(resp_dep2), 32'(m_dep2));
    endtask

    task automatic tick();
        int w;
        w = model_winner();
        @(posedge clk_in);
        if (rdy_in) begin
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = (w + 1) % N;
                if (rs1_of(w) == 5'd0) begin
                    m_val1 = '0; m_hd1 = 1'b0; m_dep1 = '0;
                end else begin
                    m_val1 = get_val1; m_hd1 = get_has_dep1; m_dep1 = get_dep1;
                end
                if (rs2_of(w) == 5'd0) begin
                    m_val2 = '0; m_hd2 = 1'b0; m_dep2 = '0;
                end else begin
                    m_val2 = get_val2; m_hd2 = get_has_dep2; m_dep2 = get_dep2;
                end
            end else begin
                m_owner = -1;
            end
        end
        last_win = w;
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        model_reset();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0;
        req_valid = '0; req_rs1 = '0; req_rs2 = '0;
        get_val1 = '0; get_val2 = '0; get_has_dep1 = 1'b0; get_has_dep2 = 1'b0;
        get_dep1 = '0; get_dep2 = '0;
        model_reset();
        @(posedge clk_in);
        #1;
        check_now();
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        rst_in = 1'b0;
        tick();

        // Single lookup from requester 1.
        req_valid = 3'b010; set_req(1, 5'd5, 5'd7);
        get_val1 = 32'h11; get_val2 = 32'h22;
        check_now();
        chk("t1_grant", 32'(req_ready), 32'b010);
        chk("t1_id1", 32'(get_id1), 32'd5);
        chk("t1_id2", 32'(get_id2), 32'd7);
        tick();
        req_valid = '0; rand_regfile();
        check_now();
        chk("t1_resp_valid", 32'(resp_valid), 32'b010);
        chk("t1_val1", resp_val1, 32'h11);
        chk("t1_val2", resp_val2, 32'h22);
        chk("t1_has_dep1", 32'(resp_has_dep1), 32'd0);
        tick();

        // Fairness with all requesters held.
        do_reset();
        req_valid = 3'b111;
        set_req(0, 5'd1, 5'd2); set_req(1, 5'd3, 5'd4); set_req(2, 5'd6, 5'd8);
        for (int c = 0; c < 6; c++) begin
            rand_regfile();
            check_now();
            chk("fair_grant", 32'(req_ready), 32'(onehot(c % 3)));
            if (c > 0) chk("fair_owner", 32'(resp_valid), 32'(onehot((c - 1) % 3)));
            tick();
        end
        req_valid = '0;

        // x0 sanitisation on rs1.
        req_valid = 3'b001; set_req(0, 5'd0, 5'd3);
        get_val1 = 32'hdead; get_has_dep1 = 1'b1; get_dep1 = 4'd4;
        get_val2 = 32'h33; get_has_dep2 = 1'b1; get_dep2 = 4'd2;
        check_now();
        tick();
        req_valid = '0; rand_regfile();
        check_now();
        chk("x0_val1", resp_val1, 32'd0);
        chk("x0_has_dep1", 32'(resp_has_dep1), 32'd0);
        chk("x0_dep1", 32'(resp_dep1), 32'd0);
        chk("x0_val2", resp_val2, 32'h33);
        chk("x0_has_dep2", 32'(resp_has_dep2), 32'd1);
        chk("x0_dep2", 32'(resp_dep2), 32'd2);
        tick();

        // Flush in the response cycle.
        req_valid = 3'b100; set_req(2, 5'd9, 5'd10); rand_regfile();
        check_now();
        chk("flush_pre_grant", 32'(req_ready), 32'b100);
        tick();
        rob_clear = 1'b1; req_valid = 3'b111;
        check_now();
        chk("flush_resp_valid", 32'(resp_valid), 32'd0);
        chk("flush_grant", 32'(req_ready), 32'd0);
        tick();
        rob_clear = 1'b0;
        check_now();
        chk("flush_after_resp", 32'(resp_valid), 32'd0);
        chk("flush_resume", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;

        // Stall with rdy_in low for three cycles.
        req_valid = 3'b010; set_req(1, 5'd11, 5'd12); rand_regfile();
        sv1 = get_val1; sv2 = get_val2;
        check_now();
        chk("stall_pre_grant", 32'(req_ready), 32'b010);
        tick();
        rdy_in = 1'b0; req_valid = 3'b111;
        for (int c = 0; c < 3; c++) begin
            rand_regfile();
            check_now();
            chk("stall_resp_valid", 32'(resp_valid), 32'b010);
            chk("stall_val1", resp_val1, sv1);
            chk("stall_val2", resp_val2, sv2);
            chk("stall_grant", 32'(req_ready), 32'd0);
            chk("stall_rr_ptr", 32'(dut.rr_ptr), 32'd2);
            tick();
        end
        rdy_in = 1'b1; req_valid = '0;
        check_now();
        tick();

        // Asynchronous reset while a response is pending.
        req_valid = 3'b100; set_req(2, 5'd13, 5'd14); rand_regfile();
        check_now();
        tick();
        req_valid = '0;
        #2;
        chk("arst_pre_resp", 32'(resp_valid), 32'b100);
        rst_in = 1'b1;
        #1;
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        chk("arst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        chk("arst_val1", resp_val1, 32'd0);
        model_reset();
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // Randomized traffic with requesters honouring the hold-until-transfer rule.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && last_win == i) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    if (req_valid[i]) set_req(i, rid(), rid());
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    set_req(i, rid(), rid());
                end
            end
            rob_clear = ($urandom_range(0, 9) == 0);
            rdy_in    = ($urandom_range(0, 5) != 0);
            rand_regfile();
            check_now();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
